cpu_run_ctrl: RTL and testbench

//  Run/halt sequencer for the pipeline: drives cpu_en (the global run enable that also gates the statistic counters).

---
 rtl/cpu_run_ctrl_pkg.sv | 22 ++
 rtl/cpu_run_ctrl_debounce.sv | 58 +++++
 rtl/cpu_run_ctrl.sv | 98 +++++++++
 tb/tb_cpu_run_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the run/halt sequencer:
// FSM state encoding, syscall service codes and a run-state helper.
package cpu_run_ctrl_pkg;

    // State encoding is visible on run_state (debug LEDs), so values are fixed.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_PAUSE = 3'd3,
        S_HALT  = 3'd4
    } run_state_e;

    localparam logic [31:0] HALT_CODE_DEF  = 32'd10;
    localparam logic [31:0] PAUSE_CODE_DEF = 32'd50;

    // The pipeline is enabled only in the two executing states.
    function automatic logic is_exec(run_state_e s);
        return (s == S_RUN) || (s == S_STEP);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_debounce.sv
// Front-panel button conditioner: synchronizer, stability counter,
// debounced level and a single-cycle rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int          DB_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise_pulse
);

    localparam logic [DB_W-1:0] W_LAST = DB_W'(DB_CYCLES - 1);

    logic            r_s1;
    logic            r_s2;
    logic            r_s2_d;
    logic [DB_W-1:0] r_cnt;
    logic            r_level;
    logic            r_level_d;
    logic            r_armed;

    // Synchronize, count stable cycles, accept the level once it has settled.
    // r_s2_d resets opposite to r_s2 so the first post-reset cycle restarts
    // the count. r_armed stays low until a released level has been accepted,
    // so a button held through reset cannot fire.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s2_d    <= 1'b1;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_s1      <= btn_in;
            r_s2      <= r_s1;
            r_s2_d    <= r_s2;
            r_level_d <= r_level;
            if (r_s2 != r_s2_d) begin
                r_cnt <= '0;
            end else if (r_cnt == W_LAST) begin
                r_level <= r_s2;
                if (!r_s2) begin
                    r_armed <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level      = r_level;
    assign rise_pulse = r_level & ~r_level_d & r_armed;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer: drives the global pipeline enable from the GO
// button, the step/free-run switch and halt/pause syscalls.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 500000,
    parameter int          DB_W       = 20,
    parameter logic [31:0] HALT_CODE  = HALT_CODE_DEF,
    parameter logic [31:0] PAUSE_CODE = PAUSE_CODE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall_t,
    input  logic [31:0] A,
    input  logic        go_btn,
    input  logic        step_mode,
    output logic        cpu_en,
    output logic        halted,
    output logic        paused,
    output logic [2:0]  run_state
);

    logic       w_go;
    logic       w_level;
    logic       w_halt_hit;
    logic       w_pause_hit;
    run_state_e w_next;
    run_state_e w_resume;

    run_state_e r_state;
    logic       r_cpu_en;
    logic       r_halted;
    logic       r_paused;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_go_db (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (go_btn),
        .level      (w_level),
        .rise_pulse (w_go)
    );

    // Gating by cpu_en keeps a stalled syscall from being seen twice.
    assign w_halt_hit  = r_cpu_en & syscall_t & (A == HALT_CODE);
    assign w_pause_hit = r_cpu_en & syscall_t & (A == PAUSE_CODE);
    assign w_resume    = step_mode ? S_STEP : S_RUN;

    // Next-state selection; halt beats pause beats GO.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_go) w_next = w_resume;
            end
            S_RUN: begin
                if (w_halt_hit)       w_next = S_HALT;
                else if (w_pause_hit) w_next = S_PAUSE;
                else if (w_go)        w_next = S_PAUSE;
            end
            S_STEP: begin
                w_next = w_halt_hit ? S_HALT : S_PAUSE;
            end
            S_PAUSE: begin
                if (w_go) w_next = w_resume;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register with outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cpu_en <= 1'b0;
            r_halted <= 1'b0;
            r_paused <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cpu_en <= is_exec(w_next);
            r_halted <= (w_next == S_HALT);
            r_paused <= (w_next == S_PAUSE);
        end
    end

    assign cpu_en    = r_cpu_en;
    assign halted    = r_halted;
    assign paused    = r_paused;
    assign run_state = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        syscall_t;
    logic [31:0] A;
    logic        go_btn;
    logic        step_mode;
    logic        cpu_en;
    logic        halted;
    logic        paused;
    logic [2:0]  run_state;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: 0 idle, 1 run, 2 step, 3 pause, 4 halt.
    int m_state;
    bit m_pulse;
    bit m_level;
    bit m_armed;
    bit hist[$];

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .DB_CYCLES (4),
        .DB_W      (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .syscall_t (syscall_t),
        .A         (A),
        .go_btn    (go_btn),
        .step_mode (step_mode),
        .cpu_en    (cpu_en),
        .halted    (halted),
        .paused    (paused),
        .run_state (run_state)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    function automatic bit m_exec();
        return (m_state == 1) || (m_state == 2);
    endfunction

    // One clock of the reference model, evaluated at the posedge.
    task automatic model_step();
        bit go, hh, ph, all1, all0;
        int n, resume;
        if (!rst) begin
            m_state = 0;
            m_pulse = 0;
            m_level = 0;
            m_armed = 0;
            hist.delete();
            // the two cleared synchronizer stages behave like two low samples
            hist.push_back(1'b0);
            hist.push_back(1'b0);
            return;
        end
        go     = m_pulse;
        hh     = m_exec() && syscall_t && (A == 32'd10);
        ph     = m_exec() && syscall_t && (A == 32'd50);
        resume = step_mode ? 2 : 1;
        case (m_state)
            0: if (go) m_state = resume;
            1: if (hh) m_state = 4;
               else if (ph || go) m_state = 3;
            2: m_state = hh ? 4 : 3;
            3: if (go) m_state = resume;
            default: m_state = 4;
        endcase
        // A level is accepted once the raw button, seen two cycles late,
        // has held the same value for DB_CYCLES+1 consecutive samples.
        hist.push_back(go_btn);
        while (hist.size() > 7) void'(hist.pop_front());
        m_pulse = 0;
        n = hist.size();
        if (n == 7) begin
            all1 = 1;
            all0 = 1;
            for (int k = 0; k < 5; k++) begin
                if (hist[k]) all0 = 0;
                else all1 = 0;
            end
            if (all1) begin
                if (!m_level && m_armed) m_pulse = 1;
                m_level = 1;
            end else if (all0) begin
                m_level = 0;
                m_armed = 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("run_state", 32'(run_state), 32'(m_state));
        check("cpu_en", 32'(cpu_en), 32'(m_exec()));
        check("halted", 32'(halted), 32'(m_state == 4));
        check("paused", 32'(paused), 32'(m_state == 3));
    endtask

    task automatic press(int hold, int gap);
        go_btn = 1'b1;
        repeat (hold) cyc();
        go_btn = 1'b0;
        repeat (gap) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        repeat (10) cyc();
    endtask

    initial begin
        int lat, en_cnt, run_len, max_run, btn_left;
        bit seen;
        rst       = 1'b0;
        syscall_t = 1'b0;
        A         = 32'd0;
        go_btn    = 1'b0;
        step_mode = 1'b0;
        #1;

        // reset and idle
        do_reset();
        repeat (10) cyc();
        check("idle_state", 32'(run_state), 32'd0);

        // press latency and long hold
        go_btn = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (run_state == 3'd1 && lat == 0) lat = i;
        end
        go_btn = 1'b0;
        repeat (10) cyc();
        check("go_latency", 32'(lat), 32'd8);
        check("run_after_hold", 32'(run_state), 32'd1);

        // short glitch in RUN is ignored
        press(3, 10);
        check("glitch_run", 32'(run_state), 32'd1);

        // halt syscall, then GO ignored
        syscall_t = 1'b1;
        A = 32'd10;
        check("halt_cyc_en", 32'(cpu_en), 32'd1);
        cyc();
        syscall_t = 1'b0;
        check("halt_en_off", 32'(cpu_en), 32'd0);
        check("halted", 32'(halted), 32'd1);
        press(10, 10);
        check("halt_sticky", 32'(run_state), 32'd4);

        // pause syscall; syscalls ignored while paused
        do_reset();
        press(10, 10);
        syscall_t = 1'b1;
        A = 32'd50;
        cyc();
        check("paused", 32'(paused), 32'd1);
        A = 32'd10;
        repeat (5) cyc();
        syscall_t = 1'b0;
        check("pause_ign_halt", 32'(run_state), 32'd3);
        A = 32'd7;
        press(10, 10);
        check("resume_run", 32'(run_state), 32'd1);

        // unrelated syscall code
        syscall_t = 1'b1;
        A = 32'd11;
        repeat (3) cyc();
        syscall_t = 1'b0;
        check("other_code", 32'(run_state), 32'd1);

        // single-step: manual pause then three steps
        step_mode = 1'b1;
        press(10, 10);
        check("manual_pause", 32'(run_state), 32'd3);
        en_cnt  = 0;
        run_len = 0;
        max_run = 0;
        for (int p = 0; p < 3; p++) begin
            go_btn = 1'b1;
            for (int i = 0; i < 20; i++) begin
                if (i == 10) go_btn = 1'b0;
                cyc();
                if (cpu_en) begin
                    en_cnt++;
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else begin
                    run_len = 0;
                end
            end
        end
        check("step_count", 32'(en_cnt), 32'd3);
        check("step_width", 32'(max_run), 32'd1);
        check("step_pause", 32'(run_state), 32'd3);

        // halt coincident with a step cycle
        syscall_t = 1'b1;
        A = 32'd10;
        press(10, 10);
        syscall_t = 1'b0;
        check("step_halt", 32'(run_state), 32'd4);

        // halt and GO in the same cycle
        step_mode = 1'b0;
        do_reset();
        press(10, 10);
        go_btn = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            seen = m_pulse;
        end
        check("pulse_seen", 32'(seen), 32'd1);
        syscall_t = 1'b1;
        A = 32'd10;
        cyc();
        syscall_t = 1'b0;
        go_btn = 1'b0;
        check("halt_over_go", 32'(run_state), 32'd4);

        // reset mid-run
        do_reset();
        press(10, 10);
        rst = 1'b0;
        cyc();
        check("rst_state", 32'(run_state), 32'd0);
        check("rst_en", 32'(cpu_en), 32'd0);
        rst = 1'b1;

        // button held through reset gives no pulse until re-pressed
        go_btn = 1'b1;
        rst = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        repeat (15) cyc();
        check("held_rst", 32'(run_state), 32'd0);
        go_btn = 1'b0;
        repeat (10) cyc();
        press(10, 10);
        check("repress_run", 32'(run_state), 32'd1);

        // random stimulus
        btn_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (btn_left == 0) begin
                go_btn   = ~go_btn;
                btn_left = $urandom_range(1, 12);
            end
            btn_left--;
            syscall_t = ($urandom % 6) == 0;
            case ($urandom % 4)
                0: A = 32'd10;
                1: A = 32'd50;
                2: A = $urandom;
                default: A = 32'd11;
            endcase
            if ($urandom % 40 == 0) step_mode = ~step_mode;
            rst = ($urandom % 150) != 0;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
